// File: rtl/sdram_pkg.sv
// SDRAM command encodings shared by the PHY and its read pipe.
package sdram_pkg;

    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } sdram_cmd_t;

    function automatic logic is_read(input logic cs_n, input logic [2:0] cmd);
        return (cs_n == 1'b0) && (cmd == CMD_READ);
    endfunction

endpackage

// File: rtl/sdram_rd_pipe.sv
// Read beat tracking: beat-valid/last shift registers, capture flop and
// RD_EXTRA retiming stages. Bit 0 of the shift registers means "a read beat is on the pins now".
module sdram_rd_pipe
    import sdram_pkg::*;
#(
    parameter int DQ_W        = 16,
    parameter int CAS_LATENCY = 2,
    parameter int BURST_LEN   = 1,
    parameter int RD_EXTRA    = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rd_start,
    input  logic [DQ_W-1:0] cap_src,
    output logic            beat_now,
    output logic [DQ_W-1:0] rd_data,
    output logic            rd_valid,
    output logic            rd_last
);

    localparam int DEPTH = CAS_LATENCY + BURST_LEN + 1;
    // A READ decoded in cycle t lands its first beat at bit 0 in cycle t+1+CAS_LATENCY.
    localparam logic [DEPTH-1:0] VLD_MASK =
        {{(DEPTH-BURST_LEN){1'b0}}, {BURST_LEN{1'b1}}} << CAS_LATENCY;
    localparam logic [DEPTH-1:0] LST_MASK =
        {{(DEPTH-1){1'b0}}, 1'b1} << (CAS_LATENCY + BURST_LEN - 1);

    logic [DEPTH-1:0]  vld_sr_r;
    logic [DEPTH-1:0]  lst_sr_r;
    logic [RD_EXTRA:0] stg_vld_r;
    logic [RD_EXTRA:0] stg_lst_r;
    logic [DQ_W-1:0]   data_r [RD_EXTRA+1];

    // Beat scheduling, capture and retiming; data stages only load on a valid beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr_r  <= '0;
            lst_sr_r  <= '0;
            stg_vld_r <= '0;
            stg_lst_r <= '0;
            for (int i = 0; i <= RD_EXTRA; i++) begin
                data_r[i] <= '0;
            end
        end else begin
            vld_sr_r     <= {1'b0, vld_sr_r[DEPTH-1:1]} | (rd_start ? VLD_MASK : '0);
            lst_sr_r     <= {1'b0, lst_sr_r[DEPTH-1:1]} | (rd_start ? LST_MASK : '0);
            stg_vld_r[0] <= vld_sr_r[0];
            stg_lst_r[0] <= lst_sr_r[0];
            if (vld_sr_r[0]) begin
                data_r[0] <= cap_src;
            end
            for (int i = 1; i <= RD_EXTRA; i++) begin
                stg_vld_r[i] <= stg_vld_r[i-1];
                stg_lst_r[i] <= stg_lst_r[i-1];
                if (stg_vld_r[i-1]) begin
                    data_r[i] <= data_r[i-1];
                end
            end
        end
    end

    assign beat_now = vld_sr_r[0];
    assign rd_data  = data_r[RD_EXTRA];
    assign rd_valid = stg_vld_r[RD_EXTRA];
    assign rd_last  = stg_lst_r[RD_EXTRA];

endmodule

// File: rtl/sdram_phy.sv
// SDRAM PHY: one register stage to the pads, DQ output-enable control and read capture.
// Optional SDRAM_PHY_LOOPBACK_EN adds an lpbk port that routes dq_o back into the capture path.
module sdram_phy
    import sdram_pkg::*;
#(
    parameter int DQ_W        = 16,
    parameter int ADDR_W      = 13,
    parameter int BA_W        = 2,
    parameter int CAS_LATENCY = 2,
    parameter int BURST_LEN   = 1,
    parameter int RD_EXTRA    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                core_cke,
    input  logic                core_cs_n,
    input  logic [2:0]          core_cmd,
    input  logic [DQ_W/8-1:0]   core_dqm,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [BA_W-1:0]     core_ba,
    input  logic [DQ_W-1:0]     core_wr_data,
    input  logic                core_wr_en,
    output logic [DQ_W-1:0]     core_rd_data,
    output logic                core_rd_valid,
    output logic                core_rd_last,
    output logic                bus_conflict,
    output logic                sdram_cke,
    output logic                sdram_cs_n,
    output logic                sdram_ras_n,
    output logic                sdram_cas_n,
    output logic                sdram_we_n,
    output logic [DQ_W/8-1:0]   sdram_dqm,
    output logic [ADDR_W-1:0]   sdram_a,
    output logic [BA_W-1:0]     sdram_ba,
    output logic [DQ_W-1:0]     dq_o,
    output logic                dq_oe,
`ifdef SDRAM_PHY_LOOPBACK_EN
    input  logic                lpbk,
`endif
    input  logic [DQ_W-1:0]     dq_i
);

    localparam int DQM_W = DQ_W / 8;

    logic              cke_r;
    logic              cs_n_r;
    logic [2:0]        cmd_r;
    logic [DQM_W-1:0]  dqm_r;
    logic [ADDR_W-1:0] a_r;
    logic [BA_W-1:0]   ba_r;
    logic [DQ_W-1:0]   dq_o_r;
    logic              dq_oe_r;
    logic              bus_conflict_r;
    logic              oe_next_s;
    logic              conflict_s;
    logic              beat_now_s;
    logic [DQ_W-1:0]   cap_src_s;
    logic              rd_start_s;

    assign rd_start_s = is_read(core_cs_n, core_cmd);

    // Loopback suppresses the pad driver and feeds the dq_o register back as read data.
    always_comb begin
        oe_next_s  = core_wr_en;
        conflict_s = dq_oe_r & beat_now_s;
        cap_src_s  = dq_i;
`ifdef SDRAM_PHY_LOOPBACK_EN
        if (lpbk) begin
            oe_next_s  = 1'b0;
            conflict_s = 1'b0;
            cap_src_s  = dq_o_r;
        end else begin
            oe_next_s  = core_wr_en;
            conflict_s = dq_oe_r & beat_now_s;
            cap_src_s  = dq_i;
        end
`endif
    end

    // Pin register stage and sticky write/read collision flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cke_r          <= 1'b0;
            cs_n_r         <= 1'b1;
            cmd_r          <= CMD_NOP;
            dqm_r          <= '1;
            a_r            <= '0;
            ba_r           <= '0;
            dq_o_r         <= '0;
            dq_oe_r        <= 1'b0;
            bus_conflict_r <= 1'b0;
        end else begin
            cke_r          <= core_cke;
            cs_n_r         <= core_cs_n;
            cmd_r          <= core_cmd;
            dqm_r          <= core_dqm;
            a_r            <= core_addr;
            ba_r           <= core_ba;
            dq_o_r         <= core_wr_data;
            dq_oe_r        <= oe_next_s;
            bus_conflict_r <= bus_conflict_r | conflict_s;
        end
    end

    sdram_rd_pipe #(
        .DQ_W        (DQ_W),
        .CAS_LATENCY (CAS_LATENCY),
        .BURST_LEN   (BURST_LEN),
        .RD_EXTRA    (RD_EXTRA)
    ) u_rd_pipe (
        .clk      (clk),
        .rst      (rst),
        .rd_start (rd_start_s),
        .cap_src  (cap_src_s),
        .beat_now (beat_now_s),
        .rd_data  (core_rd_data),
        .rd_valid (core_rd_valid),
        .rd_last  (core_rd_last)
    );

    assign sdram_cke    = cke_r;
    assign sdram_cs_n   = cs_n_r;
    assign sdram_ras_n  = cmd_r[2];
    assign sdram_cas_n  = cmd_r[1];
    assign sdram_we_n   = cmd_r[0];
    assign sdram_dqm    = dqm_r;
    assign sdram_a      = a_r;
    assign sdram_ba     = ba_r;
    assign dq_o         = dq_o_r;
    assign dq_oe        = dq_oe_r;
    assign bus_conflict = bus_conflict_r;

endmodule

// File: tb/tb_sdram_phy.sv
// Self-checking bench for sdram_phy: two instances (CL2/BL1/RE0 and CL3/BL4/RE1) against a
// cycle-indexed schedule model of read beats, pin registration and conflict flag.
module tb_sdram_phy;
    import sdram_pkg::*;

    localparam int N   = 1024;
    localparam int CL0 = 2, BL0 = 1, RE0 = 0;
    localparam int CL1 = 3, BL1 = 4, RE1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, core_cke, core_cs_n, core_wr_en, lpbk;
    logic [2:0]  core_cmd;
    logic [1:0]  core_dqm;
    logic [12:0] core_addr;
    logic [1:0]  core_ba;
    logic [15:0] core_wr_data, dq_i_a, dq_i_b;

    logic [15:0] rd_data_a, rd_data_b, dq_o_a, dq_o_b, dq_oe_dummy;
    logic        rd_valid_a, rd_valid_b, rd_last_a, rd_last_b, conf_a, conf_b;
    logic        cke_a, cs_n_a, ras_a, cas_a, we_a, dq_oe_a;
    logic        cke_b, cs_n_b, ras_b, cas_b, we_b, dq_oe_b;
    logic [1:0]  dqm_a, dqm_b, ba_a, ba_b;
    logic [12:0] a_a, a_b;

    sdram_phy #(.CAS_LATENCY(CL0), .BURST_LEN(BL0), .RD_EXTRA(RE0)) dut_a (
        .clk(clk), .rst(rst), .core_cke(core_cke), .core_cs_n(core_cs_n), .core_cmd(core_cmd),
        .core_dqm(core_dqm), .core_addr(core_addr), .core_ba(core_ba),
        .core_wr_data(core_wr_data), .core_wr_en(core_wr_en),
        .core_rd_data(rd_data_a), .core_rd_valid(rd_valid_a), .core_rd_last(rd_last_a),
        .bus_conflict(conf_a), .sdram_cke(cke_a), .sdram_cs_n(cs_n_a), .sdram_ras_n(ras_a),
        .sdram_cas_n(cas_a), .sdram_we_n(we_a), .sdram_dqm(dqm_a), .sdram_a(a_a),
        .sdram_ba(ba_a), .dq_o(dq_o_a), .dq_oe(dq_oe_a),
`ifdef SDRAM_PHY_LOOPBACK_EN
        .lpbk(lpbk),
`endif
        .dq_i(dq_i_a));

    sdram_phy #(.CAS_LATENCY(CL1), .BURST_LEN(BL1), .RD_EXTRA(RE1)) dut_b (
        .clk(clk), .rst(rst), .core_cke(core_cke), .core_cs_n(core_cs_n), .core_cmd(core_cmd),
        .core_dqm(core_dqm), .core_addr(core_addr), .core_ba(core_ba),
        .core_wr_data(core_wr_data), .core_wr_en(core_wr_en),
        .core_rd_data(rd_data_b), .core_rd_valid(rd_valid_b), .core_rd_last(rd_last_b),
        .bus_conflict(conf_b), .sdram_cke(cke_b), .sdram_cs_n(cs_n_b), .sdram_ras_n(ras_b),
        .sdram_cas_n(cas_b), .sdram_we_n(we_b), .sdram_dqm(dqm_b), .sdram_a(a_b),
        .sdram_ba(ba_b), .dq_o(dq_o_b), .dq_oe(dq_oe_b),
`ifdef SDRAM_PHY_LOOPBACK_EN
        .lpbk(lpbk),
`endif
        .dq_i(dq_i_b));

    // Reference model: expected read beats per output cycle, pin-beat cycles, recorded pad data.
    bit          exp_vld [2][N];
    bit          exp_lst [2][N];
    bit          pin_beat[2][N];
    int          src_cyc [2][N];
    logic [15:0] dq_rec  [2][N];
    bit          lp_rec  [N];
    logic [15:0] dqo_rec [N];
    logic [15:0] exp_data[2];
    bit          exp_conf[2];

    bit          prev_rst, prev_cke, prev_cs_n, prev_wr_en, prev_lpbk;
    logic [2:0]  prev_cmd;
    logic [1:0]  prev_dqm, prev_ba;
    logic [12:0] prev_addr;
    logic [15:0] prev_wr_data;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit armed  = 1'b0;
    logic [15:0] cnt_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
        end
    endtask

    function automatic logic [15:0] src_value(input int i, input int p);
        return lp_rec[p] ? dqo_rec[p] : dq_rec[i][p];
    endfunction

    task automatic sched(input int i, input int c);
        int cl, bl, re, pin, o;
        cl = (i == 0) ? CL0 : CL1;
        bl = (i == 0) ? BL0 : BL1;
        re = (i == 0) ? RE0 : RE1;
        for (int k = 0; k < bl; k++) begin
            pin = c + 1 + cl + k;
            o   = c + cl + re + 2 + k;
            pin_beat[i][pin] = 1'b1;
            exp_vld[i][o]    = 1'b1;
            src_cyc[i][o]    = pin;
            if (k == bl - 1) exp_lst[i][o] = 1'b1;
        end
    endtask

    // Advance to the next cycle and compare every observable against the model.
    task automatic tick();
        logic [15:0] obs_d;
        logic        obs_v, obs_l, obs_c;
        @(posedge clk);
        #1;
        cyc++;
        if (armed) begin
            if (prev_rst) begin
                chk("rst_cke", 32'(cke_a), 32'(1'b0));
                chk("rst_cmd", 32'({cs_n_a, ras_a, cas_a, we_a}), 32'(4'b1111));
                chk("rst_dqm_a_ba", 32'({dqm_a, a_a, ba_a}), 32'({2'b11, 13'd0, 2'b00}));
                chk("rst_dq_o", 32'(dq_o_a), 32'(16'h0000));
                chk("rst_dq_oe", 32'({dq_oe_a, dq_oe_b}), 32'(2'b00));
            end else begin
                chk("pin_cke", 32'(cke_a), 32'(prev_cke));
                chk("pin_cmd", 32'({cs_n_a, ras_a, cas_a, we_a}), 32'({prev_cs_n, prev_cmd}));
                chk("pin_cmd_b", 32'({cs_n_b, ras_b, cas_b, we_b}), 32'({prev_cs_n, prev_cmd}));
                chk("pin_dqm_a_ba", 32'({dqm_a, a_a, ba_a}), 32'({prev_dqm, prev_addr, prev_ba}));
                chk("dq_oe", 32'({dq_oe_a, dq_oe_b}),
                    32'({2{prev_wr_en & ~prev_lpbk}}));
                if (prev_wr_en) chk("dq_o", 32'({dq_o_a, dq_o_b}), {prev_wr_data, prev_wr_data});
            end
            for (int i = 0; i < 2; i++) begin
                if (exp_vld[i][cyc]) exp_data[i] = src_value(i, src_cyc[i][cyc]);
                obs_v = (i == 0) ? rd_valid_a : rd_valid_b;
                obs_l = (i == 0) ? rd_last_a  : rd_last_b;
                obs_d = (i == 0) ? rd_data_a  : rd_data_b;
                obs_c = (i == 0) ? conf_a     : conf_b;
                chk((i == 0) ? "rd_valid_a" : "rd_valid_b", 32'(obs_v), 32'(exp_vld[i][cyc]));
                chk((i == 0) ? "rd_last_a"  : "rd_last_b",  32'(obs_l), 32'(exp_lst[i][cyc]));
                chk((i == 0) ? "rd_data_a"  : "rd_data_b",  32'(obs_d), 32'(exp_data[i]));
                chk((i == 0) ? "conflict_a" : "conflict_b", 32'(obs_c), 32'(exp_conf[i]));
            end
        end
    endtask

    // Drive the inputs for the current cycle and record them in the model.
    task automatic drive(input bit r, input bit cs_n, input logic [2:0] cmd, input bit we,
                         input logic [15:0] wd, input bit force_dq, input logic [15:0] dqv);
        bit oe_now;
        rst        = r;
        core_cs_n  = cs_n;
        core_cmd   = cmd;
        core_wr_en = we;
        if (we) core_wr_data = wd;
        core_cke   = 1'($urandom);
        core_dqm   = 2'($urandom);
        core_addr  = 13'($urandom);
        core_ba    = 2'($urandom);
        dq_i_a     = force_dq ? dqv : 16'($urandom);
        dq_i_b     = force_dq ? dqv : 16'($urandom);
        oe_now     = armed && !prev_rst && prev_wr_en && !prev_lpbk;
        dq_rec[0][cyc] = dq_i_a;
        dq_rec[1][cyc] = dq_i_b;
        lp_rec[cyc]    = lpbk;
        dqo_rec[cyc]   = prev_wr_data;
        if (r) begin
            for (int i = 0; i < 2; i++) begin
                for (int d = 1; d <= 16; d++) begin
                    exp_vld[i][cyc+d]  = 1'b0;
                    exp_lst[i][cyc+d]  = 1'b0;
                    pin_beat[i][cyc+d] = 1'b0;
                end
                exp_data[i] = 16'h0000;
                exp_conf[i] = 1'b0;
            end
            armed = 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (oe_now && pin_beat[i][cyc] && !lpbk) exp_conf[i] = 1'b1;
            end
            if (!cs_n && cmd == CMD_READ) begin
                sched(0, cyc);
                sched(1, cyc);
            end
        end
        prev_rst = r; prev_cke = core_cke; prev_cs_n = cs_n; prev_cmd = cmd;
        prev_dqm = core_dqm; prev_addr = core_addr; prev_ba = core_ba;
        prev_wr_en = we; prev_wr_data = core_wr_data; prev_lpbk = lpbk;
    endtask

    task automatic step(input bit r, input bit cs_n, input logic [2:0] cmd, input bit we,
                        input logic [15:0] wd, input bit force_dq, input logic [15:0] dqv);
        tick();
        drive(r, cs_n, cmd, we, wd, force_dq, dqv);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, CMD_NOP, 1'b0, 16'h0000, 1'b0, 16'h0000);
    endtask

    initial begin
        lpbk         = 1'b0;
        core_wr_data = 16'h0000;
        prev_wr_data = 16'h0000;
        drive(1'b1, 1'b1, CMD_NOP, 1'b0, 16'h0000, 1'b0, 16'h0000);
        step(1'b1, 1'b1, CMD_NOP, 1'b0, 16'h0000, 1'b0, 16'h0000);

        // Idle after reset.
        idle(8);

        // Single-beat read on a with a fixed pad value.
        step(1'b0, 1'b0, CMD_READ, 1'b0, 16'h0000, 1'b1, 16'hA5C3);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, CMD_NOP, 1'b0, 16'h0000, 1'b1, 16'hA5C3);
        idle(4);

        // Two reads four cycles apart; pads return an incrementing count.
        cnt_val = 16'd0;
        step(1'b0, 1'b0, CMD_READ, 1'b0, 16'h0000, 1'b1, cnt_val);
        for (int k = 1; k < 16; k++) begin
            cnt_val = 16'(k);
            if (k == 4) step(1'b0, 1'b0, CMD_READ, 1'b0, 16'h0000, 1'b1, cnt_val);
            else        step(1'b0, 1'b1, CMD_NOP, 1'b0, 16'h0000, 1'b1, cnt_val);
        end
        idle(4);

        // Two-beat write.
        step(1'b0, 1'b0, CMD_WRITE, 1'b1, 16'h1111, 1'b0, 16'h0000);
        step(1'b0, 1'b1, CMD_NOP,   1'b1, 16'h2222, 1'b0, 16'h0000);
        idle(4);

        // Write colliding with a read beat, then a read cut off by reset.
        step(1'b1, 1'b1, CMD_NOP, 1'b0, 16'h0000, 1'b0, 16'h0000);
        step(1'b0, 1'b0, CMD_READ, 1'b0, 16'h0000, 1'b0, 16'h0000);
        idle(1);
        step(1'b0, 1'b0, CMD_WRITE, 1'b1, 16'h3C3C, 1'b0, 16'h0000);
        idle(7);
        step(1'b0, 1'b0, CMD_READ, 1'b0, 16'h0000, 1'b0, 16'h0000);
        idle(1);
        step(1'b1, 1'b1, CMD_NOP, 1'b0, 16'h0000, 1'b0, 16'h0000);
        idle(12);

        // Randomized traffic with overlapping reads, writes and occasional resets.
        for (int k = 0; k < 500; k++) begin
            bit r, cs_n, we;
            logic [2:0] cmd;
            r    = ($urandom_range(0, 59) == 0);
            we   = ($urandom_range(0, 4) == 0);
            cmd  = 3'($urandom);
            cs_n = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cmd  = CMD_READ;
                cs_n = 1'b0;
            end
            step(r, cs_n, cmd, we, 16'($urandom), 1'b0, 16'h0000);
        end
        idle(12);

`ifdef SDRAM_PHY_LOOPBACK_EN
        // Loopback: the write beat is returned as read data, the pad stays undriven.
        lpbk = 1'b1;
        step(1'b1, 1'b1, CMD_NOP, 1'b0, 16'h0000, 1'b0, 16'h0000);
        step(1'b0, 1'b0, CMD_READ, 1'b0, 16'h0000, 1'b0, 16'h0000);
        idle(1);
        step(1'b0, 1'b0, CMD_WRITE, 1'b1, 16'hBEEF, 1'b0, 16'h0000);
        idle(8);
        lpbk = 1'b0;
        idle(4);
`endif

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
